// File: rtl/packet_fwd_ctrl_if.sv
// FIFO-side signal bundle for packet_fwd_ctrl: header and payload FWFT read
// ports plus the output FIFO write port.
interface packet_fwd_ctrl_if;
    logic        header_fifo_empty;
    logic [31:0] header_fifo_data;
    logic        header_fifo_rd_en;
    logic        rxfifo_empty;
    logic [31:0] rxfifo_data;
    logic        rxfifo_rd_en;
    logic        txfifo_full;
    logic        txfifo_wr_en;
    logic [31:0] txfifo_data;

    modport master (
        input  header_fifo_empty,
        input  header_fifo_data,
        output header_fifo_rd_en,
        input  rxfifo_empty,
        input  rxfifo_data,
        output rxfifo_rd_en,
        input  txfifo_full,
        output txfifo_wr_en,
        output txfifo_data
    );

    modport slave (
        output header_fifo_empty,
        output header_fifo_data,
        input  header_fifo_rd_en,
        output rxfifo_empty,
        output rxfifo_data,
        input  rxfifo_rd_en,
        output txfifo_full,
        input  txfifo_wr_en,
        input  txfifo_data
    );
endinterface

// File: rtl/packet_fwd_ctrl.sv
// Packet forwarding controller: copies header + payload words from the FWFT
// header/rx FIFOs into the tx FIFO and discards packets longer than MAX_LEN.
//
// state      | meaning
// IDLE       | waiting for enable and a header; no strobes
// HDR        | forward the header word once tx has room
// PAYLOAD    | forward `remaining` rx words, stalling on empty/full
// DROP       | pop oversize header, then discard its payload words
module packet_fwd_ctrl #(
    parameter int MAX_LEN = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    packet_fwd_ctrl_if.master  fifo,
    output logic               busy,
    output logic               pkt_done,
    output logic               err_len,
    output logic [15:0]        pkt_count,
    output logic [7:0]         drop_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    logic [1:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_remaining;
    logic        r_drop_hdr;
    logic        r_pkt_done;
    logic        r_err_len;
    logic [15:0] r_pkt_count;
    logic [7:0]  r_drop_count;

    logic        w_start;
    logic        w_oversize;
    logic        w_hdr_xfer;
    logic        w_pay_xfer;
    logic        w_drop_hdr_pop;
    logic        w_drop_rx_pop;
    logic        w_last;
    logic [15:0] w_remaining_dec;

    assign w_start    = enable && !fifo.header_fifo_empty;
    assign w_oversize = {1'b0, fifo.header_fifo_data[15:0]} > MAX_LEN_W;

    // Strobes are gated by reset_n so a reset mid-packet stops traffic at once.
    assign w_hdr_xfer     = reset_n && (r_state == ST_HDR)
                            && !fifo.txfifo_full && !fifo.header_fifo_empty;
    assign w_pay_xfer     = reset_n && (r_state == ST_PAYLOAD)
                            && !fifo.rxfifo_empty && !fifo.txfifo_full;
    assign w_drop_hdr_pop = reset_n && (r_state == ST_DROP) && r_drop_hdr
                            && !fifo.header_fifo_empty;
    assign w_drop_rx_pop  = reset_n && (r_state == ST_DROP) && !r_drop_hdr
                            && !fifo.rxfifo_empty;

    assign w_last          = (r_remaining <= 16'd1);
    assign w_remaining_dec = (r_remaining != 16'd0) ? (r_remaining - 16'd1) : 16'd0;

    assign fifo.header_fifo_rd_en = w_hdr_xfer || w_drop_hdr_pop;
    assign fifo.rxfifo_rd_en      = w_pay_xfer || w_drop_rx_pop;
    assign fifo.txfifo_wr_en      = w_hdr_xfer || w_pay_xfer;
    assign fifo.txfifo_data       = w_hdr_xfer ? fifo.header_fifo_data :
                                    w_pay_xfer ? fifo.rxfifo_data : 32'h0;

    assign busy       = (r_state != ST_IDLE);
    assign pkt_done   = r_pkt_done;
    assign err_len    = r_err_len;
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_len        <= 16'd0;
            r_remaining  <= 16'd0;
            r_drop_hdr   <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_err_len    <= 1'b0;
            r_pkt_count  <= 16'd0;
            r_drop_count <= 8'd0;
        end else begin
            r_pkt_done <= 1'b0;
            r_err_len  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_len <= fifo.header_fifo_data[15:0];
                        if (w_oversize) begin
                            r_state     <= ST_DROP;
                            r_remaining <= fifo.header_fifo_data[15:0];
                            r_drop_hdr  <= 1'b1;
                            r_err_len   <= 1'b1;
                        end else begin
                            r_state <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (w_hdr_xfer) begin
                        r_remaining <= r_len;
                        if (r_len == 16'd0) begin
                            r_state     <= ST_IDLE;
                            r_pkt_done  <= 1'b1;
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end else begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_pay_xfer) begin
                        r_remaining <= w_remaining_dec;
                        if (w_last) begin
                            r_state     <= ST_IDLE;
                            r_pkt_done  <= 1'b1;
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_drop_hdr_pop) begin
                        r_drop_hdr <= 1'b0;
                    end else if (w_drop_rx_pop) begin
                        r_remaining <= w_remaining_dec;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            if (r_drop_count != 8'hFF) begin
                                r_drop_count <= r_drop_count + 8'd1;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_fwd_ctrl.sv
// Self-checking bench for packet_fwd_ctrl with queue-based FIFO models and a
// packet-level reference (forward header+payload if len <= MAX_LEN, else drop).
module tb_packet_fwd_ctrl;
    localparam int MAXL = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        busy;
    logic        pkt_done;
    logic        err_len;
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;

    packet_fwd_ctrl_if fifo_if ();

    packet_fwd_ctrl #(.MAX_LEN(MAXL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo       (fifo_if),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .err_len    (err_len),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [15:0] tag;
        int          mode;
        int          e_tx;
        int          e_rx;
        int          e_done;
        int          e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] hq[$];
    logic [31:0] rxq[$];
    logic [31:0] tx_log[$];
    logic [31:0] exp_tx[$];
    int          push_cyc[$];
    int cyc, n_tx, n_rx, n_hdr, n_done, n_err, n_busy, viol;
    int full_mode = 0;
    bit rand_hold = 1'b0;
    int model_pkt = 0;
    int model_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic show_queues(input bit hdr_hold, input bit rx_hold);
        fifo_if.header_fifo_empty = (hq.size() == 0) || hdr_hold;
        fifo_if.header_fifo_data  = (hq.size() != 0) ? hq[0] : 32'h0;
        fifo_if.rxfifo_empty      = (rxq.size() == 0) || rx_hold;
        fifo_if.rxfifo_data       = (rxq.size() != 0) ? rxq[0] : 32'h0;
    endtask

    task automatic drive_flags();
        bit hh, rh;
        hh = rand_hold && ($urandom_range(0, 3) == 0);
        rh = rand_hold && ($urandom_range(0, 3) == 0);
        case (full_mode)
            1:       fifo_if.txfifo_full = ~fifo_if.txfifo_full;
            2:       fifo_if.txfifo_full = ($urandom_range(0, 2) == 0);
            default: fifo_if.txfifo_full = 1'b0;
        endcase
        show_queues(hh, rh);
    endtask

    // One clock: observe strobes at negedge, let the DUT edge happen, then
    // present the FIFO contents for the next cycle.
    task automatic tick();
        logic [31:0] d;
        @(negedge clk);
        cyc++;
        if (busy) n_busy++;
        if (fifo_if.header_fifo_rd_en) begin
            if (fifo_if.header_fifo_empty) viol++;
            else begin d = hq.pop_front(); n_hdr++; end
        end
        if (fifo_if.rxfifo_rd_en) begin
            if (fifo_if.rxfifo_empty) viol++;
            else begin d = rxq.pop_front(); n_rx++; end
        end
        if (fifo_if.txfifo_wr_en) begin
            if (fifo_if.txfifo_full) viol++;
            else begin
                tx_log.push_back(fifo_if.txfifo_data);
                push_cyc.push_back(cyc);
                n_tx++;
            end
        end
        if (pkt_done) n_done++;
        if (err_len) n_err++;
        @(posedge clk);
        #1;
        drive_flags();
    endtask

    task automatic clear_mon();
        cyc = 0; n_tx = 0; n_rx = 0; n_hdr = 0; n_done = 0; n_err = 0; n_busy = 0; viol = 0;
        push_cyc.delete();
        tx_log.delete();
    endtask

    task automatic load_packet(input logic [15:0] len, input logic [15:0] tag);
        logic [31:0] w;
        hq.push_back({tag, len});
        if (int'(len) <= MAXL) begin
            exp_tx.push_back({tag, len});
            model_pkt = (model_pkt + 1) % 65536;
        end else begin
            model_drop = (model_drop < 255) ? model_drop + 1 : 255;
        end
        for (int i = 0; i < int'(len); i++) begin
            w = $urandom();
            rxq.push_back(w);
            if (int'(len) <= MAXL) exp_tx.push_back(w);
        end
        show_queues(1'b0, 1'b0);
    endtask

    task automatic run_until_idle(input int budget, input string name, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while ((busy || (hq.size() != 0 && enable)) && k < budget);
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s_timeout: ran %0d cycles, limit %0d", name, k, budget);
        end
        tick();
        tick();
    endtask

    task automatic check_stream(input string name);
        int mism;
        mism = 0;
        chk({name, "_tx_count"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            if (tx_log[i] !== exp_tx[i]) mism++;
        chk({name, "_tx_words"}, mism, 0);
        exp_tx.delete();
        tx_log.delete();
    endtask

    task automatic check_counts(input string name);
        chk({name, "_pkt_count"}, 32'(pkt_count), model_pkt);
        chk({name, "_drop_count"}, 32'(drop_count), model_drop);
        chk({name, "_protocol"}, viol, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        int          k, span, rd, re, rx_total, rx_before, tx_before;
        logic [15:0] len;

        vecs[0] = '{16'd3,  16'h00A5, 0, 4,  3,  1, 0};
        vecs[1] = '{16'd0,  16'h0011, 0, 1,  0,  1, 0};
        vecs[2] = '{16'd20, 16'h0BAD, 0, 0,  20, 0, 1};
        vecs[3] = '{16'd4,  16'h0044, 1, 5,  4,  1, 0};
        vecs[4] = '{16'd16, 16'h0016, 2, 17, 16, 1, 0};
        vecs[5] = '{16'd17, 16'h0017, 2, 0,  17, 0, 1};
        vecs[6] = '{16'd1,  16'h0001, 1, 2,  1,  1, 0};

        reset_n = 1'b0;
        enable  = 1'b1;
        fifo_if.txfifo_full = 1'b0;
        drive_flags();
        clear_mon();
        repeat (3) tick();

        chk("rst_busy",       32'(busy), 0);
        chk("rst_pkt_done",   32'(pkt_done), 0);
        chk("rst_err_len",    32'(err_len), 0);
        chk("rst_pkt_count",  32'(pkt_count), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_strobes",    32'({fifo_if.header_fifo_rd_en, fifo_if.rxfifo_rd_en, fifo_if.txfifo_wr_en}), 0);
        chk("rst_tx_data",    fifo_if.txfifo_data, 0);

        // Normal packet starting on the first cycle out of reset.
        clear_mon();
        load_packet(16'd3, 16'h00A5);
        reset_n = 1'b1;
        tick();
        chk("start_after_reset", 32'(busy), 1);
        run_until_idle(100, "normal", k);
        span = (push_cyc.size() >= 4) ? (push_cyc[3] - push_cyc[0]) : -1;
        chk("normal_push_span", span, 3);
        chk("normal_busy_cycles", n_busy, 4);
        chk("normal_done_pulses", n_done, 1);
        chk("normal_rx_pops", n_rx, 3);
        check_counts("normal");
        check_stream("normal");

        for (int v = 0; v < 7; v++) begin
            full_mode = vecs[v].mode;
            clear_mon();
            load_packet(vecs[v].len, vecs[v].tag);
            run_until_idle(400, $sformatf("vec%0d", v), k);
            chk($sformatf("vec%0d_tx_pushes", v), n_tx, vecs[v].e_tx);
            chk($sformatf("vec%0d_rx_pops", v), n_rx, vecs[v].e_rx);
            chk($sformatf("vec%0d_done_pulses", v), n_done, vecs[v].e_done);
            chk($sformatf("vec%0d_err_pulses", v), n_err, vecs[v].e_err);
            chk($sformatf("vec%0d_hdr_pops", v), n_hdr, 1);
            check_counts($sformatf("vec%0d", v));
            check_stream($sformatf("vec%0d", v));
        end
        full_mode = 0;

        // Back-to-back: one IDLE cycle between packets, N+2 cycles each.
        clear_mon();
        load_packet(16'd2, 16'h0B01);
        load_packet(16'd2, 16'h0B02);
        run_until_idle(100, "b2b", k);
        chk("b2b_cycles", k, 8);
        chk("b2b_busy_cycles", n_busy, 6);
        chk("b2b_done_pulses", n_done, 2);
        check_counts("b2b");
        check_stream("b2b");

        // Enable dropped mid-packet: current packet finishes, next stays queued.
        clear_mon();
        load_packet(16'd2, 16'h0E01);
        load_packet(16'd1, 16'h0E02);
        tick();
        enable = 1'b0;
        run_until_idle(100, "en_off", k);
        repeat (4) tick();
        chk("en_off_done_pulses", n_done, 1);
        chk("en_off_hdr_left", hq.size(), 1);
        chk("en_off_busy", 32'(busy), 0);
        enable = 1'b1;
        run_until_idle(100, "en_on", k);
        chk("en_on_done_pulses", n_done, 2);
        check_counts("en");
        check_stream("en");

        // pkt_count wrap from 0xFFFF.
        clear_mon();
        force dut.r_pkt_count = 16'hFFFF;
        #2;
        release dut.r_pkt_count;
        chk("wrap_preload", 32'(pkt_count), 32'hFFFF);
        model_pkt = 65535;
        load_packet(16'd1, 16'h0FFF);
        run_until_idle(100, "wrap", k);
        chk("wrap_pkt_count", 32'(pkt_count), 0);
        check_counts("wrap");
        check_stream("wrap");

        // Randomized traffic with random stalls on every FIFO.
        clear_mon();
        full_mode = 2;
        rand_hold = 1'b1;
        rd = 0; re = 0; rx_total = 0;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 9) < 7) len = 16'($urandom_range(0, MAXL));
            else                          len = 16'($urandom_range(MAXL + 1, MAXL + 8));
            load_packet(len, 16'($urandom()));
            if (int'(len) <= MAXL) rd++; else re++;
            rx_total += int'(len);
        end
        run_until_idle(8000, "rand", k);
        chk("rand_done_pulses", n_done, rd);
        chk("rand_err_pulses", n_err, re);
        chk("rand_rx_pops", n_rx, rx_total);
        chk("rand_hdr_pops", n_hdr, 40);
        check_counts("rand");
        check_stream("rand");
        rand_hold = 1'b0;

        // drop_count saturation.
        clear_mon();
        for (int p = 0; p < 256; p++) load_packet(16'd17, 16'h0D00);
        run_until_idle(8000, "drop_sat", k);
        chk("drop_sat_value", 32'(drop_count), 255);
        chk("drop_sat_err_pulses", n_err, 256);
        chk("drop_sat_tx_pushes", n_tx, 0);
        check_counts("drop_sat");
        check_stream("drop_sat");
        full_mode = 0;

        // Reset during PAYLOAD.
        clear_mon();
        load_packet(16'd5, 16'h0C05);
        repeat (3) tick();
        chk("rst_mid_busy_before", 32'(busy), 1);
        reset_n = 1'b0;
        rx_before = n_rx;
        tx_before = n_tx;
        tick();
        chk("rst_mid_no_rx_pop", n_rx, rx_before);
        chk("rst_mid_no_tx_push", n_tx, tx_before);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_pkt_count", 32'(pkt_count), 0);
        chk("rst_mid_drop_count", 32'(drop_count), 0);
        chk("rst_mid_pkt_done", 32'(pkt_done), 0);
        chk("rst_mid_err_len", 32'(err_len), 0);
        chk("rst_mid_strobes", 32'({fifo_if.header_fifo_rd_en, fifo_if.rxfifo_rd_en, fifo_if.txfifo_wr_en}), 0);
        chk("rst_mid_tx_data", fifo_if.txfifo_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_fwd_ctrl.md
PACKET_FWD_CTRL -- requirements
Module: packet_fwd_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 1024: largest legal payload length in 32-bit words; range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  high allows new packets to start; low blocks only new packets.
REQ-005 header_fifo_empty  input  1  header FIFO empty flag.
REQ-006 header_fifo_data  input  32  header word, first-word-fall-through (FWFT), valid while !header_fifo_empty; [15:0] = payload length, [31:16] = tag.
REQ-007 header_fifo_rd_en  output  1  pop header FIFO this cycle.
REQ-008 rxfifo_empty  input  1  payload FIFO empty flag.
REQ-009 rxfifo_data  input  32  payload word, FWFT, valid while !rxfifo_empty.
REQ-010 rxfifo_rd_en  output  1  pop payload FIFO this cycle.
REQ-011 txfifo_full  input  1  output FIFO full flag.
REQ-012 txfifo_wr_en  output  1  push txfifo_data into output FIFO this cycle.
REQ-013 txfifo_data  output  32  word being pushed.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 pkt_done  output  1  one-cycle pulse per packet fully forwarded.
REQ-016 err_len  output  1  one-cycle pulse when an oversize header is accepted.
REQ-017 pkt_count  output  16  forwarded-packet counter; wraps at 16 bits.
REQ-018 drop_count  output  8  dropped-packet counter; saturates at 255.

Function
REQ-019 FSM states: IDLE, HDR, PAYLOAD, DROP; state register and counters are registered.
REQ-020 Output timing: header_fifo_rd_en, rxfifo_rd_en, txfifo_wr_en and txfifo_data are combinational from state and the current flags; pkt_done and err_len are registered.
REQ-021 Push and pop qualification:
- Never assert a pop while the matching FIFO's empty flag is high.
- Never assert txfifo_wr_en while txfifo_full is high.
REQ-022 IDLE, packet start: if enable && !header_fifo_empty, latch len = header_fifo_data[15:0].
- 1 <= len <= MAX_LEN, or len == 0: go to HDR.
- len > MAX_LEN: go to DROP.
REQ-023 IDLE outputs: no pops and no pushes are asserted in IDLE.
REQ-024 HDR, header transfer: in a cycle with !txfifo_full:
- assert header_fifo_rd_en and txfifo_wr_en together, with txfifo_data = header_fifo_data;
- load remaining = len.
REQ-025 HDR exit:
- len == 0: go to IDLE and pulse pkt_done next cycle.
- otherwise: go to PAYLOAD.
- If txfifo_full, stay in HDR with no strobes.
REQ-026 PAYLOAD: in each cycle with !rxfifo_empty && !txfifo_full:
- assert rxfifo_rd_en and txfifo_wr_en together, with txfifo_data = rxfifo_data;
- decrement remaining.
- Any other cycle is a stall with no strobes.
REQ-027 PAYLOAD completion: when the word transferred has remaining == 1, go to IDLE, pulse pkt_done in the following cycle, and increment pkt_count.
REQ-028 DROP entry: on entry, pop the header (header_fifo_rd_en for one cycle, no tx push), pulse err_len, and load remaining = len.
REQ-029 DROP discard: in each cycle with !rxfifo_empty, pop one rx word with no tx push and decrement remaining. txfifo_full is ignored in DROP.
REQ-030 DROP completion: after the last word, go to IDLE and increment drop_count, saturating at 255. pkt_done is not pulsed.
REQ-031 enable deasserted mid-packet: the current packet completes normally. Only the IDLE start is blocked.
REQ-032 Back-to-back packets: IDLE is occupied for at least one cycle between packets. Minimum packet time is N+2 cycles for N payload words with no stalls.
REQ-033 Counter arithmetic:
- remaining is 16 bits and never underflows.
- pkt_count wraps 0xFFFF -> 0x0000.
- drop_count holds at 0xFF.
REQ-034 Header words are never consumed without being either forwarded or counted as dropped.

Reset
REQ-035 While reset_n is low at a clock edge, the block enters the reset state:
- state = IDLE and remaining = 0;
- pkt_count = 0 and drop_count = 0;
- pkt_done = 0, err_len = 0 and busy = 0;
- all strobes = 0 and txfifo_data = 0.
REQ-036 Reset mid-packet abandons the packet with no further pops or pushes. A partial tx packet is left in the output FIFO; flushing it is the system's responsibility.
REQ-037 The first packet start is possible in the cycle after reset_n rises.

Verification
REQ-038 Normal packet: header 0x00A5_0003, 3 rx words, tx never full -> tx receives header + 3 words in 4 consecutive push cycles; pkt_done pulses once; pkt_count = 1.
REQ-039 Backpressure: txfifo_full toggles every other cycle during a 4-word packet -> no push or pop while full; word order preserved; pkt_done pulses after the 4th word.
REQ-040 Oversize: MAX_LEN = 16, header len = 20, 20 rx words -> one err_len pulse; 20 rx pops; 0 tx pushes; drop_count = 1; pkt_count unchanged.
REQ-041 Zero length: header len = 0 -> header forwarded alone; pkt_done pulses; no rx pops.
REQ-042 Enable/reset: enable dropped mid-packet -> packet completes and the next header is not popped; reset_n low mid-PAYLOAD -> next cycle state = IDLE, all outputs at reset values.
REQ-043 Wrap: preload 65535 packets (or force pkt_count = 0xFFFF), send one packet -> pkt_count = 0x0000.
